// File: rtl/peripheral_port_arbiter.sv
// -----------------------------------------------------------------------------
// peripheral_port_arbiter
//
// Serialises NUM_LSU peripheral-local read/write request ports onto a single
// single-ported memory/peripheral interface. Each cycle it makes one
// combinational arbitration decision and announces the winner on the
// grant-next-cycle vectors. At the next edge it registers the winning access
// onto the oMem* strobes. It returns write-accept pulses and tagged read data
// to the LSU that owns each access.
//
// Build option:
//   PPA_ROUND_ROBIN_EN  defined   : rotating priority pointer (starvation-free)
//                       undefined : fixed priority, lowest LSU index wins
//
// Ports:
//   iClk, iReset            clock (rising edge), async active-high reset
//   iReadRequest/iWriteRequest   per-LSU request bits
//   iReadAddress/iWriteAddress   packed per-LSU addresses
//   iWriteEnable/iWriteData      packed per-LSU byte enables / write data
//   oReadGrantNextCycle/oWriteGrantNextCycle  one-hot combinational grants
//   oWriteAccept            one-cycle pulse when the granted write is performed
//   oReadData/oReadDataValid  read return, owner slice only
//   oMemAddress/oMemReadEnable/oMemWriteEnable/oMemWriteData  registered strobes
//   iMemReadData            memory read data, MEM_READ_LATENCY after the strobe
// -----------------------------------------------------------------------------
module peripheral_port_arbiter #(
  parameter int INTERFACE_WIDTH      = 32,
  parameter int INTERFACE_ADDR_WIDTH = 32,
  parameter int NUM_LSU              = 1,
  parameter int MEM_READ_LATENCY     = 1
) (
  input  logic                                   iClk,
  input  logic                                   iReset,
  input  logic [NUM_LSU-1:0]                     iReadRequest,
  input  logic [NUM_LSU-1:0]                     iWriteRequest,
  input  logic [NUM_LSU*INTERFACE_ADDR_WIDTH-1:0] iReadAddress,
  input  logic [NUM_LSU*INTERFACE_ADDR_WIDTH-1:0] iWriteAddress,
  input  logic [NUM_LSU*(INTERFACE_WIDTH/8)-1:0] iWriteEnable,
  input  logic [NUM_LSU*INTERFACE_WIDTH-1:0]     iWriteData,
  output logic [NUM_LSU-1:0]                     oReadGrantNextCycle,
  output logic [NUM_LSU-1:0]                     oWriteGrantNextCycle,
  output logic [NUM_LSU-1:0]                     oWriteAccept,
  output logic [NUM_LSU*INTERFACE_WIDTH-1:0]     oReadData,
  output logic [NUM_LSU-1:0]                     oReadDataValid,
  output logic [INTERFACE_ADDR_WIDTH-1:0]        oMemAddress,
  output logic                                   oMemReadEnable,
  output logic [INTERFACE_WIDTH/8-1:0]           oMemWriteEnable,
  output logic [INTERFACE_WIDTH-1:0]             oMemWriteData,
  input  logic [INTERFACE_WIDTH-1:0]             iMemReadData
);

  localparam int DW    = INTERFACE_WIDTH;
  localparam int AW    = INTERFACE_ADDR_WIDTH;
  localparam int BE_W  = INTERFACE_WIDTH / 8;
  localparam int IDX_W = (NUM_LSU > 1) ? $clog2(NUM_LSU) : 1;
  localparam int LAT   = MEM_READ_LATENCY;

  localparam logic [NUM_LSU-1:0] LSU0_MASK = {{(NUM_LSU-1){1'b0}}, 1'b1};

  logic [NUM_LSU-1:0] req_any;
  logic [IDX_W-1:0]   prio;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_LSU-1:0] win_mask;
  logic               win_write;
  int                 cand;
  logic [NUM_LSU-1:0] cand_mask;

  logic [AW-1:0]      sel_raddr;
  logic [AW-1:0]      sel_waddr;
  logic [BE_W-1:0]    sel_be;
  logic [DW-1:0]      sel_wd;

  logic [IDX_W-1:0]   issue_lsu;
  logic [LAT-1:0]            tag_v;
  logic [LAT-1:0][IDX_W-1:0] tag_idx;
  logic [NUM_LSU-1:0] ret_mask;

  assign req_any = iReadRequest | iWriteRequest;

  // ---------------------------------------------------------------------------
  // Priority pointer. Without rotation the search always starts at LSU 0.
  // ---------------------------------------------------------------------------
`ifdef PPA_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      rr_ptr <= '0;
    end else if (win_found) begin
      if (win_idx == IDX_W'(NUM_LSU - 1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= win_idx + IDX_W'(1);
      end
    end
  end

  assign prio = rr_ptr;
`else
  assign prio = '0;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration: search from prio upward, wrapping modulo NUM_LSU. The pointer
  // is always below NUM_LSU, so a single subtraction is enough to wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_mask = '0;
    for (int i = 0; i < NUM_LSU; i++) begin
      cand = int'(prio) + i;
      if (cand >= NUM_LSU) begin
        cand = cand - NUM_LSU;
      end
      cand_mask = LSU0_MASK << cand;
      if (!win_found && ((req_any & cand_mask) != '0)) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign win_mask  = win_found ? (LSU0_MASK << win_idx) : '0;
  // A winner with both requests pending does its write first.
  assign win_write = (iWriteRequest & win_mask) != '0;

  assign oWriteGrantNextCycle = (win_write && !iReset) ? win_mask : '0;
  assign oReadGrantNextCycle  = (win_found && !win_write && !iReset) ? win_mask : '0;

  // Winner slice selection; win_mask is one-hot or zero.
  always_comb begin
    sel_raddr = '0;
    sel_waddr = '0;
    sel_be    = '0;
    sel_wd    = '0;
    for (int k = 0; k < NUM_LSU; k++) begin
      if (win_mask[k]) begin
        sel_raddr = iReadAddress[k*AW +: AW];
        sel_waddr = iWriteAddress[k*AW +: AW];
        sel_be    = iWriteEnable[k*BE_W +: BE_W];
        sel_wd    = iWriteData[k*DW +: DW];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered memory access. Address and write data hold when idle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      oMemAddress     <= '0;
      oMemReadEnable  <= 1'b0;
      oMemWriteEnable <= '0;
      oMemWriteData   <= '0;
      oWriteAccept    <= '0;
      issue_lsu       <= '0;
    end else begin
      oMemReadEnable  <= win_found && !win_write;
      oMemWriteEnable <= win_write ? sel_be : '0;
      // Accepted even with all-zero byte enables: the access slot was used.
      oWriteAccept    <= win_write ? win_mask : '0;
      if (win_found) begin
        oMemAddress <= win_write ? sel_waddr : sel_raddr;
        issue_lsu   <= win_idx;
      end
      if (win_write) begin
        oMemWriteData <= sel_wd;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read tag pipeline. Stage 0 lines up with the first cycle after the strobe,
  // so the last stage is valid exactly when iMemReadData carries that read.
  // One entry per cycle, so returning reads can never collide.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      tag_v   <= '0;
      tag_idx <= '0;
    end else begin
      tag_v[0]   <= oMemReadEnable;
      tag_idx[0] <= issue_lsu;
      for (int i = 1; i < LAT; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  assign ret_mask       = tag_v[LAT-1] ? (LSU0_MASK << tag_idx[LAT-1]) : '0;
  assign oReadDataValid = ret_mask;

  // Only the owner's slice carries data; every other slice reads zero.
  always_comb begin
    oReadData = '0;
    for (int k = 0; k < NUM_LSU; k++) begin
      if (ret_mask[k]) begin
        oReadData[k*DW +: DW] = iMemReadData;
      end
    end
  end

endmodule

// File: tb/tb_peripheral_port_arbiter.sv
module tb_peripheral_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int N  = 4;
  localparam int L  = 2;
  localparam int BW = DW / 8;
`ifdef PPA_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      rd_req, wr_req;
  logic [N*AW-1:0]   rd_addr, wr_addr;
  logic [N*BW-1:0]   wr_be;
  logic [N*DW-1:0]   wr_data;
  logic [N-1:0]      rgrant, wgrant, wacc, rvalid;
  logic [N*DW-1:0]   rdata;
  logic [AW-1:0]     mem_addr;
  logic              mem_re;
  logic [BW-1:0]     mem_we;
  logic [DW-1:0]     mem_wd;
  logic [DW-1:0]     mem_rdata;

  always #5 clk = ~clk;

  peripheral_port_arbiter #(
    .INTERFACE_WIDTH(DW), .INTERFACE_ADDR_WIDTH(AW),
    .NUM_LSU(N), .MEM_READ_LATENCY(L)
  ) dut (
    .iClk(clk), .iReset(rst),
    .iReadRequest(rd_req), .iWriteRequest(wr_req),
    .iReadAddress(rd_addr), .iWriteAddress(wr_addr),
    .iWriteEnable(wr_be), .iWriteData(wr_data),
    .oReadGrantNextCycle(rgrant), .oWriteGrantNextCycle(wgrant),
    .oWriteAccept(wacc), .oReadData(rdata), .oReadDataValid(rvalid),
    .oMemAddress(mem_addr), .oMemReadEnable(mem_re),
    .oMemWriteEnable(mem_we), .oMemWriteData(mem_wd),
    .iMemReadData(mem_rdata)
  );

  // Environment memory: 16 words, reads appear L cycles after the strobe.
  bit [DW-1:0] mem [16];
  bit [DW-1:0] dly [L];
  always @(posedge clk) begin
    for (int b = 0; b < BW; b++)
      if (mem_we[b]) mem[mem_addr[3:0]][8*b +: 8] <= mem_wd[8*b +: 8];
    dly[0] <= mem_re ? mem[mem_addr[3:0]] : 32'h5A5A_0F0F;
    for (int i = L - 1; i > 0; i--) dly[i] <= dly[i-1];
  end
  assign mem_rdata = dly[L-1];

  // Reference model state
  int           n_chk = 0, n_fail = 0, cyc = 0, p = 0;
  bit [DW-1:0]  mmem [16];
  bit [AW-1:0]  e_addr;
  bit           e_re;
  bit [BW-1:0]  e_we;
  bit [DW-1:0]  e_wd;
  bit [N-1:0]   e_acc;
  bit           e_wr_issued;
  int           rdv_lsu  [int];
  bit [DW-1:0]  rdv_data [int];

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Winner = requesting LSU with the smallest rotational distance from p.
  function automatic int pick();
    int best = -1, bestd = N;
    for (int k = 0; k < N; k++)
      if (rd_req[k] || wr_req[k]) begin
        int d = (k - p + N) % N;
        if (d < bestd) begin bestd = d; best = k; end
      end
    return best;
  endfunction

  task automatic model_reset();
    p = 0; e_addr = '0; e_re = 0; e_we = '0; e_wd = '0; e_acc = '0; e_wr_issued = 0;
    rdv_lsu.delete(); rdv_data.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_rgrant"}, rgrant, 0);
    check_val({tag, "_wgrant"}, wgrant, 0);
    check_val({tag, "_mem_re"}, mem_re, 0);
    check_val({tag, "_mem_we"}, mem_we, 0);
    check_val({tag, "_mem_addr"}, mem_addr, 0);
    check_val({tag, "_mem_wd"}, mem_wd, 0);
    check_val({tag, "_wacc"}, wacc, 0);
    check_val({tag, "_rvalid"}, rvalid, 0);
    check_val({tag, "_rdata"}, rdata, 0);
  endtask

  // One clock: inputs are already driven (posedge+1). Optionally the winner
  // withdraws its request after seeing the grant but before the edge.
  task automatic run_cycle(input bit withdraw);
    int w;
    bit [N-1:0] eg_r, eg_w, ev;
    bit [N*DW-1:0] ed;
    w = pick();
    eg_r = '0; eg_w = '0;
    if (w >= 0) begin
      if (wr_req[w]) eg_w[w] = 1'b1; else eg_r[w] = 1'b1;
    end
    @(negedge clk);
    check_val("rgrant", rgrant, eg_r);
    check_val("wgrant", wgrant, eg_w);
    check_val("mem_re", mem_re, e_re);
    check_val("mem_we", mem_we, e_we);
    check_val("wacc", wacc, e_acc);
    if (e_re || e_wr_issued) check_val("mem_addr", mem_addr, e_addr);
    if (e_wr_issued) check_val("mem_wd", mem_wd, e_wd);
    ev = '0; ed = '0;
    if (rdv_lsu.exists(cyc)) begin
      ev[rdv_lsu[cyc]] = 1'b1;
      ed[rdv_lsu[cyc]*DW +: DW] = rdv_data[cyc];
    end
    check_val("rvalid", rvalid, ev);
    check_val("rdata", rdata, ed);
    if (withdraw && w >= 0) begin
      rd_req[w] = 1'b0; wr_req[w] = 1'b0;
      #1;
      w = pick();
      eg_r = '0; eg_w = '0;
      if (w >= 0) begin
        if (wr_req[w]) eg_w[w] = 1'b1; else eg_r[w] = 1'b1;
      end
      check_val("wd_rgrant", rgrant, eg_r);
      check_val("wd_wgrant", wgrant, eg_w);
    end
    @(posedge clk);
    e_re = 0; e_we = '0; e_acc = '0; e_wr_issued = 0;
    if (w >= 0) begin
      if (wr_req[w]) begin
        e_we = wr_be[w*BW +: BW];
        e_addr = wr_addr[w*AW +: AW];
        e_wd = wr_data[w*DW +: DW];
        e_acc[w] = 1'b1;
        e_wr_issued = 1;
        for (int b = 0; b < BW; b++)
          if (e_we[b]) mmem[e_addr[3:0]][8*b +: 8] = e_wd[8*b +: 8];
      end else begin
        e_re = 1;
        e_addr = rd_addr[w*AW +: AW];
        rdv_lsu[cyc + 1 + L]  = w;
        rdv_data[cyc + 1 + L] = mmem[e_addr[3:0]];
      end
      if (RR) p = (w + 1) % N;
    end
    cyc++;
    #1;
  endtask

  task automatic clr_req();
    rd_req = '0; wr_req = '0;
  endtask

  task automatic set_rd(input int k, input bit [AW-1:0] a);
    rd_req[k] = 1'b1; rd_addr[k*AW +: AW] = a;
  endtask

  task automatic set_wr(input int k, input bit [AW-1:0] a, input bit [DW-1:0] d, input bit [BW-1:0] be);
    wr_req[k] = 1'b1; wr_addr[k*AW +: AW] = a; wr_data[k*DW +: DW] = d; wr_be[k*BW +: BW] = be;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    clr_req();
    rd_addr = '0; wr_addr = '0; wr_be = '0; wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    rd_req = '1; wr_req = 4'b0101;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr_req();

    // Single write then read back to the same address.
    set_wr(0, 32'h10, 32'hDEAD_BEEF, 4'hF);
    run_cycle(0);
    clr_req();
    run_cycle(0);
    set_rd(0, 32'h10);
    run_cycle(0);
    clr_req();
    repeat (4) run_cycle(0);

    // All LSUs reading continuously.
    for (int k = 0; k < N; k++) set_rd(k, AW'(k * 3));
    repeat (12) run_cycle(0);
    clr_req();
    repeat (4) run_cycle(0);

    // Read+write from one LSU: write goes first, read next.
    set_wr(1, 32'h5, 32'h1234_5678, 4'b0011);
    set_rd(1, 32'h5);
    run_cycle(0);
    wr_req[1] = 1'b0;
    run_cycle(0);
    clr_req();
    repeat (4) run_cycle(0);

    // Zero byte-enable write is still granted and accepted.
    set_wr(3, 32'h7, 32'hFFFF_FFFF, 4'h0);
    run_cycle(0);
    clr_req();
    repeat (2) run_cycle(0);

    // Request withdrawn after seeing its grant.
    set_rd(2, 32'h3);
    run_cycle(1);
    clr_req();
    repeat (3) run_cycle(0);

    // Reset with two reads in flight.
    set_rd(2, 32'h10);
    set_rd(3, 32'h5);
    run_cycle(0);
    run_cycle(0);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_val("rst_rvalid", rvalid, 0);
      check_val("rst_rdata", rdata, 0);
      check_val("rst_grant", rgrant | wgrant, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr_req();
    set_rd(2, 32'h1);
    set_rd(1, 32'h2);
    run_cycle(0);
    clr_req();
    repeat (4) run_cycle(0);

    // Randomized traffic.
    repeat (600) begin
      for (int k = 0; k < N; k++) begin
        rd_req[k] = ($urandom_range(0, 1) == 1);
        wr_req[k] = ($urandom_range(0, 2) == 0);
        rd_addr[k*AW +: AW] = AW'($urandom_range(0, 15));
        wr_addr[k*AW +: AW] = AW'($urandom_range(0, 15));
        wr_data[k*DW +: DW] = $urandom;
        wr_be[k*BW +: BW]   = BW'($urandom_range(0, 15));
      end
      run_cycle($urandom_range(0, 7) == 0);
    end
    clr_req();
    repeat (6) run_cycle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
